// File: rtl/m1_frame_checker_pkg.sv
// Shared types and M1 frame defaults for the receive-side frame checker.
package m1_frame_checker_pkg;

   typedef enum logic [1:0] {
      StSearch  = 2'd0,
      StAcquire = 2'd1,
      StTrack   = 2'd2
   } state_e;

   localparam int unsigned NumErr    = 4;
   localparam int unsigned ErrBitA   = 0;
   localparam int unsigned ErrBitB   = 1;
   localparam int unsigned ErrBitFmt = 2;
   localparam int unsigned ErrBitLen = 3;

   localparam int unsigned M1FrameWords = 128;
   localparam int unsigned M1SlotA      = 2;
   localparam int unsigned M1SlotB      = 34;
   localparam int unsigned M1CntAMax    = 800;
   localparam logic [11:0] M1FillWord   = 12'h002;

endpackage

// File: rtl/m1_sat_counter.sv
// Saturating up-counter for frame statistics.
module m1_sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [Width-1:0] count
);

   logic [Width-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (inc && (count_q != '1)) begin
         count_q <= count_q + Width'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/m1_frame_checker.sv
// M1 telemetry frame checker: tracks word position, verifies slot counters and fill words,
// maintains frame lock and good/bad frame statistics.
module m1_frame_checker
   import m1_frame_checker_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = M1FrameWords,
   parameter int unsigned SLOT_A      = M1SlotA,
   parameter int unsigned SLOT_B      = M1SlotB,
   parameter int unsigned CNT_A_MAX   = M1CntAMax,
   parameter logic [11:0] FILL_WORD   = M1FillWord,
   parameter int unsigned LOCK_FRAMES = 4,
   parameter int unsigned LOSS_FRAMES = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wordStb,
   input  logic [11:0]        word,
   input  logic               frameMark,
   input  logic               grpZero,
   output logic               locked,
   output logic               frameDone,
   output logic               frameBad,
   output logic [NumErr-1:0]  errFlags,
   output logic [9:0]         cntA,
   output logic [9:0]         cntB,
   output logic [15:0]        goodFrames,
   output logic [15:0]        badFrames
);

   localparam int unsigned IdxW = $clog2(FRAME_WORDS);
   localparam int unsigned RunW = 8;
   localparam logic [IdxW-1:0]   LastIdx = IdxW'(FRAME_WORDS - 1);
   localparam logic [IdxW-1:0]   IdxA    = IdxW'(SLOT_A);
   localparam logic [IdxW-1:0]   IdxB    = IdxW'(SLOT_B);
   localparam logic [9:0]        AMax    = 10'(CNT_A_MAX);
   localparam logic [RunW-1:0]   LockRun = RunW'(LOCK_FRAMES);
   localparam logic [RunW-1:0]   LossRun = RunW'(LOSS_FRAMES);
   localparam logic [NumErr-1:0] LenFlag = NumErr'(1) << ErrBitLen;

   state_e            state_q, state_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [NumErr-1:0] flags_q, flags_d;
   logic [9:0]        ref_a_q, ref_a_d, ref_b_q, ref_b_d;
   logic              ref_gz_q, ref_gz_d;
   logic [9:0]        rx_a_q, rx_a_d, rx_b_q, rx_b_d;
   logic              rx_gz_q, rx_gz_d;
   logic [RunW-1:0]   good_run_q, good_run_d, bad_run_q, bad_run_d;
   logic              locked_q, locked_d;
   logic              done_q, done_d, bad_q, bad_d;
   logic [NumErr-1:0] err_q, err_d;
   logic [9:0]        cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

   logic              start, proc, do_eval, long_err, eval_bad;
   logic [IdxW-1:0]   proc_idx;
   logic [NumErr-1:0] word_flags, eval_flags;
   logic [9:0]        exp_a, exp_b, payload;
   logic              inc_good, inc_bad;

   assign exp_a   = (ref_a_q == AMax) ? 10'd0 : ref_a_q + 10'd1;
   assign exp_b   = ref_b_q + {9'd0, ref_gz_q};
   assign payload = word[10:1];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      flags_d    = flags_q;
      ref_a_d    = ref_a_q;
      ref_b_d    = ref_b_q;
      ref_gz_d   = ref_gz_q;
      rx_a_d     = rx_a_q;
      rx_b_d     = rx_b_q;
      rx_gz_d    = rx_gz_q;
      good_run_d = good_run_q;
      bad_run_d  = bad_run_q;
      locked_d   = locked_q;
      cnt_a_d    = cnt_a_q;
      cnt_b_d    = cnt_b_q;
      done_d     = 1'b0;
      bad_d      = 1'b0;
      err_d      = '0;
      start      = 1'b0;
      proc       = 1'b0;
      do_eval    = 1'b0;
      long_err   = 1'b0;
      eval_bad   = 1'b0;
      eval_flags = '0;
      word_flags = '0;

      // Classify the strobe: new frame, in-frame word, truncated frame or overrun.
      if (wordStb) begin
         if (state_q == StSearch) begin
            if (frameMark) begin
               start   = 1'b1;
               proc    = 1'b1;
               state_d = StAcquire;
            end
         end else if (idx_q == '0) begin
            if (frameMark) begin
               start = 1'b1;
               proc  = 1'b1;
            end else begin
               long_err = 1'b1;
            end
         end else if (frameMark) begin
            do_eval    = 1'b1;
            eval_flags = flags_q | LenFlag;
            start      = 1'b1;
            proc       = 1'b1;
         end else begin
            proc = 1'b1;
         end
      end

      proc_idx = start ? '0 : idx_q;

      if (proc) begin
         if (proc_idx == IdxA || proc_idx == IdxB) begin
            if (word[11] || word[0]) word_flags[ErrBitFmt] = 1'b1;
         end else if (word != FILL_WORD) begin
            word_flags[ErrBitFmt] = 1'b1;
         end
         if (proc_idx == IdxA) begin
            rx_a_d  = payload;
            cnt_a_d = payload;
            if (state_q == StTrack && payload != exp_a) word_flags[ErrBitA] = 1'b1;
         end
         if (proc_idx == IdxB) begin
            rx_b_d  = payload;
            cnt_b_d = payload;
            if (state_q == StTrack && payload != exp_b) word_flags[ErrBitB] = 1'b1;
         end
         if (start) rx_gz_d = grpZero;
         flags_d = (start ? '0 : flags_q) | word_flags;
         if (proc_idx == LastIdx) begin
            do_eval    = 1'b1;
            eval_flags = flags_d;
            idx_d      = '0;
         end else begin
            idx_d = proc_idx + IdxW'(1);
         end
      end

      if (do_eval) begin
         eval_bad = (eval_flags != '0);
         done_d   = 1'b1;
         bad_d    = eval_bad;
         err_d    = eval_flags;
         if (state_q == StAcquire) begin
            ref_a_d  = rx_a_q;
            ref_b_d  = rx_b_q;
            ref_gz_d = rx_gz_q;
            if (!eval_bad) begin
               state_d    = StTrack;
               good_run_d = RunW'(1);
               bad_run_d  = '0;
               if (good_run_d >= LockRun) locked_d = 1'b1;
            end
         end else if (!eval_bad) begin
            ref_a_d   = rx_a_q;
            ref_b_d   = rx_b_q;
            ref_gz_d  = rx_gz_q;
            bad_run_d = '0;
            if (good_run_q < LockRun) good_run_d = good_run_q + RunW'(1);
            if (good_run_d >= LockRun) locked_d = 1'b1;
         end else begin
            // Flywheel: carry the expected counters forward across a bad frame.
            ref_a_d    = exp_a;
            ref_b_d    = exp_b;
            ref_gz_d   = rx_gz_q;
            good_run_d = '0;
            bad_run_d  = bad_run_q + RunW'(1);
            if (bad_run_d >= LossRun) begin
               locked_d  = 1'b0;
               state_d   = StAcquire;
               bad_run_d = '0;
            end
         end
      end

      if (long_err) begin
         done_d     = 1'b1;
         bad_d      = 1'b1;
         err_d      = LenFlag;
         state_d    = StSearch;
         idx_d      = '0;
         flags_d    = '0;
         good_run_d = '0;
         bad_run_d  = '0;
         locked_d   = 1'b0;
      end

      inc_good = done_d & ~bad_d;
      inc_bad  = done_d & bad_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StSearch;
         idx_q      <= '0;
         flags_q    <= '0;
         ref_a_q    <= '0;
         ref_b_q    <= '0;
         ref_gz_q   <= 1'b0;
         rx_a_q     <= '0;
         rx_b_q     <= '0;
         rx_gz_q    <= 1'b0;
         good_run_q <= '0;
         bad_run_q  <= '0;
         locked_q   <= 1'b0;
         done_q     <= 1'b0;
         bad_q      <= 1'b0;
         err_q      <= '0;
         cnt_a_q    <= '0;
         cnt_b_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         flags_q    <= flags_d;
         ref_a_q    <= ref_a_d;
         ref_b_q    <= ref_b_d;
         ref_gz_q   <= ref_gz_d;
         rx_a_q     <= rx_a_d;
         rx_b_q     <= rx_b_d;
         rx_gz_q    <= rx_gz_d;
         good_run_q <= good_run_d;
         bad_run_q  <= bad_run_d;
         locked_q   <= locked_d;
         done_q     <= done_d;
         bad_q      <= bad_d;
         err_q      <= err_d;
         cnt_a_q    <= cnt_a_d;
         cnt_b_q    <= cnt_b_d;
      end
   end

   m1_sat_counter #(
      .Width (16)
   ) u_good_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_good),
      .count (goodFrames)
   );

   m1_sat_counter #(
      .Width (16)
   ) u_bad_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_bad),
      .count (badFrames)
   );

   assign locked    = locked_q;
   assign frameDone = done_q;
   assign frameBad  = bad_q;
   assign errFlags  = err_q;
   assign cntA      = cnt_a_q;
   assign cntB      = cnt_b_q;

endmodule

// File: tb/tb_m1_frame_checker.sv
// Scoreboard bench for m1_frame_checker: directed frames, expected evaluations queued and
// matched by an independent frameDone monitor.
module tb_m1_frame_checker;

   localparam int SlotA = 2;
   localparam int SlotB = 34;

   typedef struct packed {
      logic       bad;
      logic [3:0] flags;
      logic       lock;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        wordStb = 1'b0;
   logic [11:0] word = '0;
   logic        frameMark = 1'b0;
   logic        grpZero = 1'b0;
   logic        locked, frameDone, frameBad;
   logic [3:0]  errFlags;
   logic [9:0]  cntA, cntB;
   logic [15:0] goodFrames, badFrames;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   m1_frame_checker dut (
      .clk        (clk),
      .reset      (reset),
      .wordStb    (wordStb),
      .word       (word),
      .frameMark  (frameMark),
      .grpZero    (grpZero),
      .locked     (locked),
      .frameDone  (frameDone),
      .frameBad   (frameBad),
      .errFlags   (errFlags),
      .cntA       (cntA),
      .cntB       (cntB),
      .goodFrames (goodFrames),
      .badFrames  (badFrames)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every frameDone must match the oldest queued expectation.
   always @(negedge clk) begin
      if (frameDone === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected frameDone", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("frameBad", {31'd0, frameBad}, {31'd0, e.bad});
            check("errFlags", {28'd0, errFlags}, {28'd0, e.flags});
            check("locked", {31'd0, locked}, {31'd0, e.lock});
         end
      end
   end

   task automatic expect_frame(input logic bad, input logic [3:0] flags, input logic lock);
      exp_t e;
      e.bad   = bad;
      e.flags = flags;
      e.lock  = lock;
      exp_q.push_back(e);
   endtask

   task automatic send_word(input logic [11:0] w, input logic mark, input logic gz);
      wordStb   = 1'b1;
      word      = w;
      frameMark = mark;
      grpZero   = gz;
      @(posedge clk);
      #1;
      wordStb   = 1'b0;
      frameMark = 1'b0;
      grpZero   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int nw, input int a, input int b, input logic gz,
                             input int bad_slot);
      logic [11:0] w;
      logic [9:0]  pa, pb;
      pa = a[9:0];
      pb = b[9:0];
      for (int i = 0; i < nw; i++) begin
         if (i == SlotA)         w = {1'b0, pa, 1'b0};
         else if (i == SlotB)    w = {1'b0, pb, 1'b0};
         else if (i == bad_slot) w = 12'h003;
         else                    w = 12'h002;
         send_word(w, i == 0, (i == 0) ? gz : 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      #12;
      check("reset locked", {31'd0, locked}, 32'd0);
      check("reset frameDone", {31'd0, frameDone}, 32'd0);
      check("reset errFlags", {28'd0, errFlags}, 32'd0);
      check("reset cntA", {22'd0, cntA}, 32'd0);
      check("reset goodFrames", {16'd0, goodFrames}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2);

      // Clean stream: lock after 4th frame.
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 0, 7, 1'b1, -1);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 1, 8, 1'b0, -1);
      idle(3);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 2, 8, 1'b1, -1);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 3, 9, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 4, 9, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 5, 9, 1'b0, -1);
      idle(2);
      check("clean goodFrames", {16'd0, goodFrames}, 32'd6);
      check("clean badFrames", {16'd0, badFrames}, 32'd0);
      check("clean cntA", {22'd0, cntA}, 32'd5);
      check("clean cntB", {22'd0, cntB}, 32'd9);

      // Mid-frame reset at index 60: immediate return to reset values, no frameDone.
      send_frame(60, 6, 9, 1'b0, -1);
      reset = 1'b0;
      #1;
      check("rst locked", {31'd0, locked}, 32'd0);
      check("rst goodFrames", {16'd0, goodFrames}, 32'd0);
      check("rst cntA", {22'd0, cntA}, 32'd0);
      check("rst cntB", {22'd0, cntB}, 32'd0);
      idle(3);
      reset = 1'b1;
      idle(2);

      // Counter A wrap 799 -> 800 -> 0 -> 1.
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 799, 0, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 800, 0, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 0, 0, 1'b0, -1);
      idle(1);
      check("wrap cntA", {22'd0, cntA}, 32'd0);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 1, 0, 1'b0, -1);

      // Fill corruption in slot 50 while locked.
      expect_frame(1'b1, 4'b0100, 1'b1);
      send_frame(128, 2, 0, 1'b0, 50);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 3, 0, 1'b0, -1);

      // Loss: three wrong A values, then relock from ACQUIRE.
      expect_frame(1'b1, 4'b0001, 1'b1);
      send_frame(128, 100, 0, 1'b0, -1);
      expect_frame(1'b1, 4'b0001, 1'b1);
      send_frame(128, 100, 0, 1'b0, -1);
      expect_frame(1'b1, 4'b0001, 1'b0);
      send_frame(128, 100, 0, 1'b0, -1);
      idle(1);
      check("loss locked", {31'd0, locked}, 32'd0);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 7, 0, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 8, 0, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 9, 0, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 10, 0, 1'b0, -1);

      // Short frame: frameMark at index 100.
      expect_frame(1'b1, 4'b1000, 1'b1);
      send_frame(100, 11, 0, 1'b0, -1);
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 12, 0, 1'b0, -1);

      // Long frame: a 129th word drops to SEARCH.
      expect_frame(1'b0, 4'b0000, 1'b1);
      send_frame(128, 13, 0, 1'b0, -1);
      expect_frame(1'b1, 4'b1000, 1'b0);
      send_word(12'h002, 1'b0, 1'b0);
      idle(1);
      check("long locked", {31'd0, locked}, 32'd0);
      // Unmarked words are ignored in SEARCH; a marked frame is acquired without A/B compare.
      for (int i = 0; i < 5; i++) send_word(12'h002, 1'b0, 1'b0);
      expect_frame(1'b0, 4'b0000, 1'b0);
      send_frame(128, 500, 3, 1'b0, -1);
      idle(3);

      check("final goodFrames", {16'd0, goodFrames}, 32'd12);
      check("final badFrames", {16'd0, badFrames}, 32'd6);
      check("pending expectations", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
